// File: rtl/vision_input_controller_pkg.sv
// rtl/vision_input_controller_pkg.sv - shared command codes and lane constants
package vision_input_controller_pkg;

    typedef enum logic [1:0] {
        CMD_LEFT  = 2'd0,
        CMD_RIGHT = 2'd1,
        CMD_JUMP  = 2'd2
    } cmd_e;

    localparam logic [1:0] LANE_NONE   = 2'd3;
    localparam logic [1:0] LANE_CENTER = 2'd1;

endpackage

// File: rtl/vision_input_controller_cmd_fifo.sv
// rtl/vision_input_controller_cmd_fifo.sv - show-ahead command FIFO with flush
module cmd_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pop frees its slot first, so a push into a full FIFO with a pop is accepted
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        drop     = push && !do_push && !flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/vision_input_controller.sv
// rtl/vision_input_controller.sv - frame filter turning vision lane/jump results into game commands
module vision_input_controller
    import vision_input_controller_pkg::*;
#(
    parameter int STABLE_FRAMES = 3,
    parameter int ABSENT_FRAMES = 8,
    parameter int JUMP_FRAMES   = 2,
    parameter int CMD_DEPTH     = 4
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [1:0] lane_in,
    input  logic       jump_in,
    input  logic       data_valid_in,
    input  logic       enable_in,
    output logic       cmd_valid_out,
    input  logic       cmd_ready_in,
    output logic [1:0] cmd_out,
    output logic [1:0] lane_out,
    output logic       player_present_out,
    output logic       overflow_out
);

    localparam logic [1:0] ST_ABSENT   = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_TRACKING = 2'd2;

    localparam logic [3:0] STABLE_N = 4'(STABLE_FRAMES);
    localparam logic [3:0] ABSENT_N = 4'(ABSENT_FRAMES);
    localparam logic [3:0] JUMP_N   = 4'(JUMP_FRAMES);

    logic       data_valid_q, data_valid_d;
    logic [1:0] state_q, state_d;
    logic [1:0] lane_q, lane_d;
    logic [1:0] cand_q, cand_d;
    logic [3:0] cand_cnt_q, cand_cnt_d;
    logic [3:0] absent_cnt_q, absent_cnt_d;
    logic [3:0] jump_cnt_q, jump_cnt_d;
    logic       armed_q, armed_d;
    logic [1:0] pend_moves_q, pend_moves_d;
    cmd_e       pend_dir_q, pend_dir_d;
    logic       pend_jump_q, pend_jump_d;
    logic       overflow_q, overflow_d;

    logic       frame_evt, lost;
    logic [3:0] cnt_next, jump_next;
    logic       fifo_push, fifo_flush, fifo_full, fifo_empty, fifo_drop;
    logic [1:0] fifo_wdata;

    assign frame_evt = enable_in && data_valid_in && !data_valid_q;

    // Presence FSM, stability counters and one-per-cycle enqueue sequencer
    always_comb begin
        data_valid_d = data_valid_in;
        state_d      = state_q;
        lane_d       = lane_q;
        cand_d       = cand_q;
        cand_cnt_d   = cand_cnt_q;
        absent_cnt_d = absent_cnt_q;
        jump_cnt_d   = jump_cnt_q;
        armed_d      = armed_q;
        pend_moves_d = pend_moves_q;
        pend_dir_d   = pend_dir_q;
        pend_jump_d  = pend_jump_q;
        overflow_d   = overflow_q | fifo_drop;
        fifo_push    = 1'b0;
        fifo_wdata   = CMD_LEFT;
        fifo_flush   = 1'b0;
        cnt_next     = '0;
        jump_next    = '0;
        lost         = 1'b0;

        // Moves drain before the jump so the game sees them in lane order
        if (pend_moves_q != 2'd0) begin
            fifo_push    = 1'b1;
            fifo_wdata   = pend_dir_q;
            pend_moves_d = pend_moves_q - 2'd1;
        end else if (pend_jump_q) begin
            fifo_push   = 1'b1;
            fifo_wdata  = CMD_JUMP;
            pend_jump_d = 1'b0;
        end

        if (!enable_in) begin
            state_d      = ST_ABSENT;
            lane_d       = LANE_CENTER;
            cand_cnt_d   = '0;
            absent_cnt_d = '0;
            jump_cnt_d   = '0;
            armed_d      = 1'b1;
            pend_moves_d = '0;
            pend_jump_d  = 1'b0;
            fifo_push    = 1'b0;
            fifo_flush   = 1'b1;
            overflow_d   = 1'b0;
        end else if (frame_evt) begin
            if (state_q == ST_TRACKING) begin
                if (lane_in == LANE_NONE) begin
                    if (absent_cnt_q + 4'd1 >= ABSENT_N) begin
                        lost         = 1'b1;
                        state_d      = ST_ABSENT;
                        lane_d       = LANE_CENTER;
                        cand_cnt_d   = '0;
                        absent_cnt_d = '0;
                        jump_cnt_d   = '0;
                        armed_d      = 1'b1;
                        fifo_flush   = 1'b1;
                    end else begin
                        absent_cnt_d = absent_cnt_q + 4'd1;
                    end
                end else begin
                    absent_cnt_d = '0;
                    if (lane_in == lane_q) begin
                        cand_cnt_d = '0;
                    end else begin
                        cnt_next = (lane_in == cand_q) ? cand_cnt_q + 4'd1 : 4'd1;
                        cand_d   = lane_in;
                        if (cnt_next >= STABLE_N) begin
                            lane_d       = lane_in;
                            cand_cnt_d   = '0;
                            pend_dir_d   = (lane_in < lane_q) ? CMD_LEFT : CMD_RIGHT;
                            pend_moves_d = (lane_in > lane_q) ? lane_in - lane_q : lane_q - lane_in;
                        end else begin
                            cand_cnt_d = cnt_next;
                        end
                    end
                end
                if (!lost) begin
                    if (jump_in) begin
                        jump_next  = (jump_cnt_q >= JUMP_N) ? jump_cnt_q : jump_cnt_q + 4'd1;
                        jump_cnt_d = jump_next;
                        if (jump_next == JUMP_N && armed_q) begin
                            pend_jump_d = 1'b1;
                            armed_d     = 1'b0;
                        end
                    end else begin
                        jump_cnt_d = '0;
                        armed_d    = 1'b1;
                    end
                end
            end else begin
                if (lane_in == LANE_NONE) begin
                    state_d    = ST_ABSENT;
                    cand_cnt_d = '0;
                end else begin
                    cnt_next = (state_q == ST_ACQUIRE && lane_in == cand_q) ? cand_cnt_q + 4'd1 : 4'd1;
                    cand_d   = lane_in;
                    if (cnt_next >= STABLE_N) begin
                        state_d      = ST_TRACKING;
                        lane_d       = lane_in;
                        cand_cnt_d   = '0;
                        absent_cnt_d = '0;
                        jump_cnt_d   = '0;
                        armed_d      = 1'b1;
                    end else begin
                        state_d    = ST_ACQUIRE;
                        cand_cnt_d = cnt_next;
                    end
                end
            end
        end
    end

    // Controller state registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_valid_q <= 1'b0;
            state_q      <= ST_ABSENT;
            lane_q       <= LANE_CENTER;
            cand_q       <= '0;
            cand_cnt_q   <= '0;
            absent_cnt_q <= '0;
            jump_cnt_q   <= '0;
            armed_q      <= 1'b1;
            pend_moves_q <= '0;
            pend_dir_q   <= CMD_LEFT;
            pend_jump_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            data_valid_q <= data_valid_d;
            state_q      <= state_d;
            lane_q       <= lane_d;
            cand_q       <= cand_d;
            cand_cnt_q   <= cand_cnt_d;
            absent_cnt_q <= absent_cnt_d;
            jump_cnt_q   <= jump_cnt_d;
            armed_q      <= armed_d;
            pend_moves_q <= pend_moves_d;
            pend_dir_q   <= pend_dir_d;
            pend_jump_q  <= pend_jump_d;
            overflow_q   <= overflow_d;
        end
    end

    cmd_fifo #(
        .WIDTH (2),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (cmd_ready_in),
        .pop_data  (cmd_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign cmd_valid_out      = !fifo_empty;
    assign lane_out           = lane_q;
    assign player_present_out = (state_q == ST_TRACKING);
    assign overflow_out       = overflow_q;

endmodule

// File: tb/tb_vision_input_controller.sv
// tb/tb_vision_input_controller.sv - randomized self-checking bench for vision_input_controller
module tb_vision_input_controller;
    import vision_input_controller_pkg::*;

    localparam int STABLE = 3;
    localparam int ABSN   = 8;
    localparam int JF     = 2;
    localparam int DEPTH  = 4;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic [1:0] lane_in;
    logic       jump_in;
    logic       data_valid_in;
    logic       enable_in;
    logic       cmd_valid_out;
    logic       cmd_ready_in;
    logic [1:0] cmd_out;
    logic [1:0] lane_out;
    logic       player_present_out;
    logic       overflow_out;

    vision_input_controller #(
        .STABLE_FRAMES (STABLE),
        .ABSENT_FRAMES (ABSN),
        .JUMP_FRAMES   (JF),
        .CMD_DEPTH     (DEPTH)
    ) dut (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .lane_in            (lane_in),
        .jump_in            (jump_in),
        .data_valid_in      (data_valid_in),
        .enable_in          (enable_in),
        .cmd_valid_out      (cmd_valid_out),
        .cmd_ready_in       (cmd_ready_in),
        .cmd_out            (cmd_out),
        .lane_out           (lane_out),
        .player_present_out (player_present_out),
        .overflow_out       (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference model: presence mode plus run lengths of recent frames
    int m_mode;      // 0 no player, 1 locking on, 2 following
    int m_lane, m_cand, m_run, m_miss, m_jump_run;
    bit m_armed, m_ovf;
    int exp_fifo[$];
    int hs_n = 0;
    int hs_cyc[$];
    int ev_cyc;

    function automatic void model_reset();
        m_mode = 0; m_lane = 1; m_cand = 0; m_run = 0; m_miss = 0;
        m_jump_run = 0; m_armed = 1; m_ovf = 0;
        exp_fifo.delete();
    endfunction

    function automatic void model_push(int c);
        if (exp_fifo.size() >= DEPTH) m_ovf = 1;
        else exp_fifo.push_back(c);
    endfunction

    function automatic void model_frame(int l, int j);
        if (m_mode == 2) begin
            if (l == 3) begin
                m_miss++;
                if (m_miss >= ABSN) begin
                    m_mode = 0; m_lane = 1; m_run = 0; m_miss = 0; m_jump_run = 0; m_armed = 1;
                    exp_fifo.delete();
                    return;
                end
            end else begin
                m_miss = 0;
                if (l == m_lane) m_run = 0;
                else begin
                    m_run = (l == m_cand) ? m_run + 1 : 1;
                    m_cand = l;
                    if (m_run >= STABLE) begin
                        for (int k = 0; k < ((l > m_lane) ? l - m_lane : m_lane - l); k++)
                            model_push((l < m_lane) ? 0 : 1);
                        m_lane = l;
                        m_run = 0;
                    end
                end
            end
            if (j != 0) begin
                m_jump_run = (m_jump_run + 1 > JF) ? JF : m_jump_run + 1;
                if (m_jump_run == JF && m_armed) begin
                    model_push(2);
                    m_armed = 0;
                end
            end else begin
                m_jump_run = 0;
                m_armed = 1;
            end
        end else if (l == 3) begin
            m_mode = 0; m_run = 0;
        end else begin
            m_run = (m_mode == 1 && l == m_cand) ? m_run + 1 : 1;
            m_cand = l;
            if (m_run >= STABLE) begin
                m_mode = 2; m_lane = l; m_run = 0; m_miss = 0; m_jump_run = 0; m_armed = 1;
            end else m_mode = 1;
        end
    endfunction

    // Every accepted command is matched against the model's queue in order
    always @(negedge clk_in) begin
        if (rst_n_in === 1'b1 && cmd_valid_out === 1'b1 && cmd_ready_in === 1'b1) begin
            hs_n++;
            hs_cyc.push_back(cyc);
            if (exp_fifo.size() == 0) check("cmd_unexpected_qsize", exp_fifo.size(), 1);
            else check("cmd_order", cmd_out, exp_fifo.pop_front());
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    task automatic post_check();
        check("lane_out", lane_out, m_lane);
        check("present", player_present_out, (m_mode == 2) ? 1 : 0);
        check("overflow", overflow_out, m_ovf);
        if (cmd_ready_in) begin
            check("cmd_valid_idle", cmd_valid_out, 0);
            check("cmd_missing_qsize", exp_fifo.size(), 0);
        end else begin
            check("cmd_valid_held", cmd_valid_out, (exp_fifo.size() > 0) ? 1 : 0);
            if (exp_fifo.size() > 0) check("cmd_head_held", cmd_out, exp_fifo[0]);
        end
    endtask

    task automatic frame(input int l, input int j);
        lane_in = 2'(l);
        jump_in = j[0];
        data_valid_in = 1'b1;
        ev_cyc = cyc;
        model_frame(l, j);
        step(3);
        data_valid_in = 1'b0;
        step(8);
        post_check();
    endtask

    task automatic frames(input int l, input int j, input int n);
        for (int i = 0; i < n; i++) frame(l, j);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int h;
        int l;
        rst_n_in = 1'b0; lane_in = 2'd0; jump_in = 1'b0; data_valid_in = 1'b0;
        enable_in = 1'b1; cmd_ready_in = 1'b1;
        model_reset();
        step(3);
        check("rst_cmd_valid", cmd_valid_out, 0);
        check("rst_cmd_out", cmd_out, 0);
        check("rst_lane", lane_out, 1);
        check("rst_present", player_present_out, 0);
        check("rst_overflow", overflow_out, 0);
        rst_n_in = 1'b1;
        step(2);

        // acquire lane 2: present only after the third agreeing frame
        frame(2, 0);
        frame(2, 0);
        check("acq_not_yet", player_present_out, 0);
        frame(2, 0);
        check("acq_lane", lane_out, 2);

        // settle at 0, then a 0->2 change gives RIGHT,RIGHT at N+2 and N+3
        frames(0, 0, 3);
        frame(2, 0);
        frame(2, 0);
        hs_cyc.delete();
        h = hs_n;
        frame(2, 0);
        check("dbl_count", hs_n - h, 2);
        check("dbl_t0", (hs_cyc.size() > 0) ? hs_cyc[0] : -1, ev_cyc + 2);
        check("dbl_t1", (hs_cyc.size() > 1) ? hs_cyc[1] : -1, ev_cyc + 3);
        check("dbl_lane", lane_out, 2);

        // jump: arm, fire once, rearm only after a 0 frame
        h = hs_n;
        frame(2, 1); frame(2, 1); frame(2, 1);
        frame(2, 0); frame(2, 1); frame(2, 1);
        check("jump_count", hs_n - h, 2);

        // backpressure: five moves into a four-deep FIFO
        cmd_ready_in = 1'b0;
        frames(0, 0, 3);
        frames(2, 0, 3);
        frames(1, 0, 3);
        check("bp_overflow", overflow_out, 1);
        h = hs_n;
        cmd_ready_in = 1'b1;
        step(10);
        check("bp_handshakes", hs_n - h, 4);
        check("bp_drained_qsize", exp_fifo.size(), 0);

        // loss after eight empty frames, but not after seven
        frames(3, 0, 8);
        check("loss_present", player_present_out, 0);
        check("loss_lane", lane_out, 1);
        frames(1, 0, 3);
        frames(3, 0, 7);
        frame(1, 0);
        check("loss_keep", player_present_out, 1);

        // enable drop with a command queued
        cmd_ready_in = 1'b0;
        frames(0, 0, 3);
        check("en_pre_valid", cmd_valid_out, 1);
        enable_in = 1'b0;
        step(1);
        model_reset();
        check("en_cmd_valid", cmd_valid_out, 0);
        check("en_present", player_present_out, 0);
        check("en_lane", lane_out, 1);
        check("en_overflow", overflow_out, 0);
        enable_in = 1'b1;
        step(2);

        // asynchronous reset with a command queued
        frames(0, 0, 3);
        frames(1, 0, 3);
        check("rst2_pre_valid", cmd_valid_out, 1);
        #1;
        rst_n_in = 1'b0;
        #1;
        model_reset();
        check("rst2_cmd_valid", cmd_valid_out, 0);
        check("rst2_cmd_out", cmd_out, 0);
        check("rst2_present", player_present_out, 0);
        check("rst2_lane", lane_out, 1);
        step(2);
        rst_n_in = 1'b1;
        cmd_ready_in = 1'b1;
        step(2);

        // random frames against the model
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                frames(3, 0, 8);
            end else begin
                l = ($urandom_range(0, 9) < 2) ? 3 : int'($urandom_range(0, 2));
                frame(l, int'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
